// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR pattern generator and the PRBS checker.
// Both ends of a link import this package, so they agree on the sequence.
//   state_e        : checker FSM encoding (HUNT / LOCK)
//   default_taps() : known-good maximal-length tap masks per LFSR width
//   lfsr_predict() : next stream bit from history and tap mask
// Tap convention: TAPS[i]=1 means r[u-1-i] feeds r[u], and h[0] is the newest bit.
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int LFSR_MAX_W = 32;

  // Maximal-length masks. Width 4 gives x^4+x+1, which has period 15.
  function automatic logic [LFSR_MAX_W-1:0] default_taps(input int width);
    logic [LFSR_MAX_W-1:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0005;
      4:       taps = 32'h0000_0009;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0021;
      7:       taps = 32'h0000_0041;
      default: taps = 32'h0000_0009;
    endcase
    return taps;
  endfunction

  // Predicted next bit: XOR of the tapped history bits.
  function automatic logic lfsr_predict(input logic [LFSR_MAX_W-1:0] hist,
                                        input logic [LFSR_MAX_W-1:0] taps);
    return ^(hist & taps);
  endfunction

endpackage

// File: rtl/lfsr_hist_reg.sv
// -----------------------------------------------------------------------------
// lfsr_hist_reg
// WIDTH-bit left-shift history register. The serial input enters at bit 0, so
// hist_o[i] holds the bit received i+1 shifts ago.
//   clk_i   : rising-edge clock
//   rst_i   : asynchronous active-high clear
//   clr_i   : synchronous clear (takes priority over shift)
//   shift_i : shift enable
//   din_i   : serial input bit
//   hist_o  : current history contents
// -----------------------------------------------------------------------------
module lfsr_hist_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] hist_o
);

  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] hist_d;

  // Next history: clear, shift in a new bit, or hold.
  always_comb begin
    if (clr_i) begin
      hist_d = {WIDTH{1'b0}};
    end else if (shift_i) begin
      hist_d = {hist_q[WIDTH-2:0], din_i};
    end else begin
      hist_d = hist_q;
    end
  end

  // History storage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= {WIDTH{1'b0}};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_checker
// Receive-side PRBS checker. It seeds its reference LFSR from the first WIDTH
// valid bits (HUNT), then free-runs that reference and compares every valid
// bit against it (LOCK). Mismatches are pulsed and counted. A run of
// LOSS_THRESH consecutive mismatches drops the checker back to HUNT.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : din carries a stream bit this cycle
//   din       : received serial bit
//   clr_cnt   : synchronous clear of err_count (wins over an increment)
//   locked    : checker is in LOCK
//   err_pulse : previous valid bit mismatched (one cycle)
//   err_count : saturating mismatch counter
// -----------------------------------------------------------------------------
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int SEED_W = $clog2(WIDTH);
  localparam int MISS_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(WIDTH - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [SEED_W-1:0] seed_q,  seed_d;
  logic [MISS_W-1:0] miss_q,  miss_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              pulse_q, pulse_d;

  logic [WIDTH-1:0]  hist_s;
  logic [WIDTH-1:0]  seed_hist_s;
  logic              expected_s;
  logic              cnt_inc_s;
  logic              loss_s;
  logic              hist_shift_s;
  logic              hist_in_s;

  lfsr_hist_reg #(
    .WIDTH (WIDTH)
  ) u_hist (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (loss_s),
    .shift_i (hist_shift_s),
    .din_i   (hist_in_s),
    .hist_o  (hist_s)
  );

  assign expected_s  = lfsr_predict(LFSR_MAX_W'(hist_s), LFSR_MAX_W'(TAPS));
  // History as it will look once the current HUNT bit is shifted in.
  assign seed_hist_s = {hist_s[WIDTH-2:0], din};

  // In LOCK the reference free-runs on its own prediction (flywheel), so a
  // corrupted input bit never pollutes the history. The losing bit is dropped.
  assign hist_shift_s = in_valid & ~loss_s;
  assign hist_in_s    = (state_q == ST_LOCK) ? expected_s : din;

  // FSM, seed and miss-run next-state logic for one valid bit.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    miss_d    = miss_q;
    pulse_d   = 1'b0;
    cnt_inc_s = 1'b0;
    loss_s    = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (seed_q == SEED_LAST) begin
            seed_d = {SEED_W{1'b0}};
            // An all-zero seed is the LFSR lock-up state: keep hunting.
            if (seed_hist_s != {WIDTH{1'b0}}) begin
              state_d = ST_LOCK;
            end else begin
              state_d = ST_HUNT;
            end
          end else begin
            seed_d = seed_q + SEED_W'(1);
          end
        end
        ST_LOCK: begin
          if (din != expected_s) begin
            pulse_d   = 1'b1;
            cnt_inc_s = 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d = ST_HUNT;
              seed_d  = {SEED_W{1'b0}};
              miss_d  = {MISS_W{1'b0}};
              loss_s  = 1'b1;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = {MISS_W{1'b0}};
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_comb begin
    if (clr_cnt) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_inc_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      seed_q  <= {SEED_W{1'b0}};
      miss_q  <= {MISS_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked    = (state_q == ST_LOCK);
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_checker
// Drives the checker with the WIDTH=4 / x^4+x+1 stream (period S), with
// deliberate bit flips, valid gaps, counter clears and resets. A behavioural
// model of the checker's rules is updated on every clock edge, and the
// outputs are compared against it on each falling edge. Literal expectations
// at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

  localparam int         W    = 4;
  localparam logic [3:0] TP   = 4'b1001;
  localparam int         LT   = 4;
  localparam int         CW   = 3;
  localparam int         CMAX = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          din;
  logic          clr_cnt;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: mh[0] is the newest reference bit.
  bit m_locked;
  bit m_pulse;
  int m_cnt;
  int m_seed;
  int m_miss;
  bit mh [W];

  bit          cmp_en = 1'b0;
  int          pulses_seen = 0;
  logic [14:0] s_pat = 15'b100011110101100;
  int          pos = 0;

  lfsr_prbs_checker #(
    .WIDTH       (W),
    .TAPS        (TP),
    .LOSS_THRESH (LT),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_expect();
    bit x = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (TP[i]) x ^= mh[i];
    end
    return x;
  endfunction

  function automatic bit m_hist_nonzero();
    bit any = 1'b0;
    for (int i = 0; i < W; i++) any |= mh[i];
    return any;
  endfunction

  task automatic m_push(input bit b);
    for (int i = W - 1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = b;
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pulse  = 1'b0;
    m_cnt    = 0;
    m_seed   = 0;
    m_miss   = 0;
    for (int i = 0; i < W; i++) mh[i] = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit e;
    m_pulse = 1'b0;
    if (v) begin
      if (!m_locked) begin
        m_push(d);
        m_seed++;
        if (m_seed == W) begin
          m_seed = 0;
          if (m_hist_nonzero()) m_locked = 1'b1;
        end
      end else begin
        e = m_expect();
        m_push(e);
        if (d != e) begin
          m_pulse = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
          m_miss++;
          if (m_miss == LT) begin
            m_locked = 1'b0;
            m_seed   = 0;
            m_miss   = 0;
            for (int i = 0; i < W; i++) mh[i] = 1'b0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) m_cnt = 0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("locked", int'(locked), int'(m_locked));
      check("err_pulse", int'(err_pulse), int'(m_pulse));
      check("err_count", int'(err_count), m_cnt);
      if (err_pulse) pulses_seen++;
    end
  end

  // One clock: apply inputs, let the edge happen, advance the model.
  task automatic step(input bit v, input bit d, input bit c);
    in_valid = v;
    din      = d;
    clr_cnt  = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
  endtask

  // Next stream bit, optionally flipped, with optional clr_cnt.
  task automatic send(input bit flip, input bit c);
    bit b;
    b   = s_pat[14 - pos];
    pos = (pos + 1) % 15;
    step(1'b1, b ^ flip, c);
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    din      = 1'b0;
    clr_cnt  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_locked", int'(locked), 0);
    check("reset_pulse", int'(err_pulse), 0);
    check("reset_count", int'(err_count), 0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // 1. Clean lock: locked rises on the cycle after the 4th bit.
    pos = 0;
    good(3);
    check("t1_not_yet_locked", int'(locked), 0);
    good(1);
    check("t1_locked", int'(locked), 1);
    pulses_seen = 0;
    good(41);
    check("t1_no_pulses", pulses_seen, 0);
    check("t1_count", int'(err_count), 0);

    // 2. Single 1->0 flip gives exactly one error, lock is kept.
    while (s_pat[14 - pos] != 1'b1) good(1);
    pulses_seen = 0;
    send(1'b1, 1'b0);
    good(15);
    check("t2_one_pulse", pulses_seen, 1);
    check("t2_count", int'(err_count), 1);
    check("t2_locked", int'(locked), 1);

    // 3. All-zero seed must not lock; the real stream then locks in 4 bits.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    check("t3_zero_no_lock", int'(locked), 0);
    pos = 0;
    good(3);
    check("t3_not_yet_locked", int'(locked), 0);
    good(1);
    check("t3_locked", int'(locked), 1);
    good(11);

    // 4. Four consecutive errors drop lock; four good bits reacquire.
    send(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    check("t4_still_locked", int'(locked), 1);
    send(1'b1, 1'b0);
    check("t4_count", int'(err_count), 4);
    check("t4_lost", int'(locked), 0);
    good(3);
    check("t4_hunting", int'(locked), 0);
    good(1);
    check("t4_relocked", int'(locked), 1);

    // 5. Saturation at 7, then clear beats a simultaneous error.
    send(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 1'b0);
      good(3);
    end
    check("t5_saturated", int'(err_count), 7);
    send(1'b1, 1'b1);
    check("t5_clr_count", int'(err_count), 0);
    check("t5_clr_pulse", int'(err_pulse), 1);
    good(4);

    // 6a. Random valid gaps with garbage din: no errors, lock held.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom), 1'b0);
      else send(1'b0, 1'b0);
    end
    check("t6_gap_count", int'(err_count), 0);
    check("t6_gap_locked", int'(locked), 1);

    // 6b. Random flips, gaps and clears, checked against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'($urandom), ($urandom_range(0, 39) == 0));
      end else begin
        send(($urandom_range(0, 11) == 0), ($urandom_range(0, 39) == 0));
      end
    end

    // 6c. Asynchronous reset between edges clears outputs immediately.
    do_reset();
    good(10);
    send(1'b1, 1'b0);
    good(1);
    check("t6_pre_rst_locked", int'(locked), 1);
    check("t6_pre_rst_count", int'(err_count), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_locked", int'(locked), 0);
    check("t6_async_count", int'(err_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    good(6);
    check("t6_relock_after_rst", int'(locked), 1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
